// File: rtl/prescale_detect_if.sv
// Bus bundle for prescale_detect: divided-clock input, measurement enable and the locked-period results.
// fsm_state exposes the detector state (0 IDLE, 1 WAIT_EDGE, 2 MEASURE, 3 LOCKED) for checkers.
interface prescale_detect_if;
    logic        en_measure;
    logic        div_in;
    logic [31:0] period_out;
    logic [4:0]  prescale_value;
    logic        valid;
    logic        error;
    logic        timeout;
    logic [1:0]  fsm_state;

    modport master (
        output en_measure, div_in,
        input  period_out, prescale_value, valid, error, timeout, fsm_state
    );

    modport slave (
        input  en_measure, div_in,
        output period_out, prescale_value, valid, error, timeout, fsm_state
    );
endinterface

// File: rtl/prescale_detect.sv
// Measures the period of a divided clock sampled as data, locks once two consecutive power-of-two periods agree.
// Define PRESCALE_DETECT_SYNC_EN to pass div_in through a 2-flop synchronizer before edge detection.
module prescale_detect #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h8000_0001
) (
    input logic             clk,
    input logic             rst,
    prescale_detect_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] prev;
    logic [31:0] period_reg;
    logic [4:0]  prescale_reg;
    logic        valid_reg;
    logic        error_reg;
    logic        timeout_reg;

    logic        div_s;
    logic        div_q;
    logic        rise;
    logic        timed_out;
    logic        m_ok;

`ifdef PRESCALE_DETECT_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= bus.div_in;
            sync_q2 <= sync_q1;
        end
    end

    assign div_s = sync_q2;
`else
    assign div_s = bus.div_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) div_q <= 1'b0;
        else     div_q <= div_s;
    end

    assign rise = div_s & ~div_q;

    function automatic logic is_pow2(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic logic [4:0] log2_minus1(input logic [31:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 1; i < 32; i++) begin
            if (v[i]) r = 5'(i - 1);
        end
        return r;
    endfunction

    // cnt never passes the limit: the timeout branch wins before another increment.
    assign timed_out = (cnt == TIMEOUT_CYCLES);
    assign m_ok      = is_pow2(cnt) && (cnt >= 32'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 32'd0;
            prev         <= 32'd0;
            period_reg   <= 32'd0;
            prescale_reg <= 5'd0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
        end else if (!bus.en_measure) begin
            state       <= IDLE;
            cnt         <= 32'd0;
            prev        <= 32'd0;
            valid_reg   <= 1'b0;
            error_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt         <= 32'd0;
                    prev        <= 32'd0;
                    valid_reg   <= 1'b0;
                    error_reg   <= 1'b0;
                    timeout_reg <= 1'b0;
                    state       <= WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        cnt   <= 32'd1;
                        state <= MEASURE;
                    end else begin
                        cnt <= 32'd0;
                    end
                end
                MEASURE, LOCKED: begin
                    if (timed_out) begin
                        timeout_reg <= 1'b1;
                        error_reg   <= 1'b1;
                        valid_reg   <= 1'b0;
                        cnt         <= 32'd0;
                        state       <= WAIT_EDGE;
                    end else if (rise) begin
                        cnt <= 32'd1;
                        if (state == MEASURE) begin
                            if (!m_ok) begin
                                error_reg <= 1'b1;
                                prev      <= 32'd0;
                            end else if (cnt == prev) begin
                                state        <= LOCKED;
                                period_reg   <= cnt;
                                prescale_reg <= log2_minus1(cnt);
                                valid_reg    <= 1'b1;
                                error_reg    <= 1'b0;
                            end else begin
                                prev <= cnt;
                            end
                        end else if (cnt != period_reg) begin
                            // Lost lock: the new period seeds the next confirmation.
                            valid_reg <= 1'b0;
                            error_reg <= 1'b1;
                            prev      <= cnt;
                            state     <= MEASURE;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
            endcase
        end
    end

    assign bus.period_out     = period_reg;
    assign bus.prescale_value = prescale_reg;
    assign bus.valid          = valid_reg;
    assign bus.error          = error_reg;
    assign bus.timeout        = timeout_reg;
    assign bus.fsm_state      = state;
endmodule

// File: tb/tb_prescale_detect.sv
// Self-checking bench for prescale_detect: directed scenarios plus randomized waveforms against a rise-timestamp model.
module tb_prescale_detect;
    localparam logic [31:0] LIMIT = 32'd100;
`ifdef PRESCALE_DETECT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    prescale_detect_if bus();

    prescale_detect #(.TIMEOUT_CYCLES(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Periods are differences between rise timestamps; a lock needs two equal power-of-two periods in a row.
    bit     model_ok;
    bit     pipe[$];
    bit     last_s;
    longint now;
    longint t_rise;
    longint held;
    int     mode;
    logic [31:0] e_period;
    logic [4:0]  e_pval;
    bit     e_valid, e_error, e_timeout;

    function automatic bit pow2(input longint v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    always @(posedge clk) begin
        bit s, r;
        longint elapsed;
        if (rst) begin
            model_ok = 1'b1;
            pipe = {};
            for (int i = 0; i < LAT; i++) pipe.push_back(1'b0);
            last_s = 0; now = 0; t_rise = 0; held = 0; mode = 0;
            e_period = 0; e_pval = 0; e_valid = 0; e_error = 0; e_timeout = 0;
        end else if (model_ok) begin
            pipe.push_back(bus.div_in);
            s = pipe.pop_front();
            r = s && !last_s;
            last_s = s;
            now++;
            elapsed = now - t_rise;
            if (!bus.en_measure) begin
                mode = 0; held = 0; e_valid = 0; e_error = 0; e_timeout = 0;
            end else if (mode == 0) begin
                mode = 1; held = 0; e_valid = 0; e_error = 0; e_timeout = 0;
            end else if (mode == 1) begin
                if (r) begin mode = 2; t_rise = now; end
            end else if (elapsed == longint'(LIMIT)) begin
                e_timeout = 1; e_error = 1; e_valid = 0; mode = 1;
            end else if (r) begin
                t_rise = now;
                if (mode == 2) begin
                    if (!pow2(elapsed)) begin
                        e_error = 1; held = 0;
                    end else if (elapsed == held) begin
                        mode = 3; e_period = 32'(elapsed); e_pval = 5'($clog2(elapsed) - 1);
                        e_valid = 1; e_error = 0;
                    end else begin
                        held = elapsed;
                    end
                end else if (elapsed != longint'(e_period)) begin
                    e_valid = 0; e_error = 1; held = elapsed; mode = 2;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            chk("period_out", bus.period_out, e_period);
            chk("prescale_value", 32'(bus.prescale_value), 32'(e_pval));
            chk("valid", 32'(bus.valid), 32'(e_valid));
            chk("error", 32'(bus.error), 32'(e_error));
            chk("timeout", 32'(bus.timeout), 32'(e_timeout));
            chk("fsm_state", 32'(bus.fsm_state), 32'(mode));
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic r, input logic e, input logic d);
        @(posedge clk);
        #3;
        rst = r;
        bus.en_measure = e;
        bus.div_in = d;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < lo; i++) drive(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < hi; i++) drive(1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic lit(input string tag, input logic [31:0] per, input logic [4:0] pv,
                       input logic v, input logic e, input logic t, input logic [1:0] st);
        chk({tag, "_period"}, bus.period_out, per);
        chk({tag, "_pval"}, 32'(bus.prescale_value), 32'(pv));
        chk({tag, "_valid"}, 32'(bus.valid), 32'(v));
        chk({tag, "_error"}, 32'(bus.error), 32'(e));
        chk({tag, "_timeout"}, 32'(bus.timeout), 32'(t));
        chk({tag, "_state"}, 32'(bus.fsm_state), 32'(st));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int kind, p, hi, lo, n;
        n_tests = 0;
        n_fail = 0;
        model_ok = 0;
        rst = 1'b1;
        bus.en_measure = 1'b0;
        bus.div_in = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        lit("reset", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);

        // clean lock at period 16
        wave(8, 8, 5);
        lit("lock16", 32'd16, 5'd3, 1'b1, 1'b0, 1'b0, 2'd3);
        // rate change to period 32: one mismatch, then relock
        wave(16, 16, 1);
        chk("rate_change_valid", 32'(bus.valid), 32'd0);
        chk("rate_change_error", 32'(bus.error), 32'd1);
        wave(16, 16, 3);
        lit("lock32", 32'd32, 5'd4, 1'b1, 1'b0, 1'b0, 2'd3);

        // stuck input after lock at period 4
        wave(2, 2, 5);
        lit("lock4", 32'd4, 5'd1, 1'b1, 1'b0, 1'b0, 2'd3);
        repeat (int'(LIMIT) + 10) drive(1'b0, 1'b1, 1'b1);
        lit("stuck", 32'd4, 5'd1, 1'b0, 1'b1, 1'b1, 2'd1);

        // bad ratio 6/6, then en_measure abort
        wave(6, 6, 4);
        chk("bad_ratio_error", 32'(bus.error), 32'd1);
        chk("bad_ratio_valid", 32'(bus.valid), 32'd0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        lit("abort_en", 32'd4, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0);

        // fastest rate
        wave(1, 1, 8);
        lit("lock2", 32'd2, 5'd0, 1'b1, 1'b0, 1'b0, 2'd3);

        // reset pulse mid-measurement
        wave(4, 4, 2);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        lit("abort_rst", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);

        // randomized waveforms, enable drops, resets and stuck stretches
        for (int seg = 0; seg < 200; seg++) begin
            kind = $urandom_range(0, 19);
            if (kind < 11) begin
                p = 1 << $urandom_range(1, 5);
                hi = $urandom_range(1, p - 1);
                lo = p - hi;
                wave(hi, lo, $urandom_range(1, 5));
            end else if (kind < 16) begin
                wave($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 4));
            end else if (kind == 16) begin
                n = $urandom_range(1, 3);
                repeat (n) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            end else if (kind == 17) begin
                drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (kind == 18) begin
                repeat (int'(LIMIT) + $urandom_range(0, 8)) drive(1'b0, 1'b1, 1'($urandom_range(0, 1) == 1));
            end else begin
                n = $urandom_range(1, 12);
                repeat (n) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            end
        end

        repeat (3) drive(1'b0, 1'b1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
